// File: rtl/robo_pkg.sv
// Shared types and helpers for the robot mission controller.
package robo_pkg;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_O = 2'b11;

  localparam int DEFAULT_BUDGET = 200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ISSUE_FWD,
    ST_ISSUE_TURN,
    ST_ISSUE_REM,
    ST_STANDBY,
    ST_FAULT
  } robo_state_e;

  // A left turn cycles N -> O -> S -> L -> N.
  function automatic logic [1:0] turn_left(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      DIR_N:   r = DIR_O;
      DIR_O:   r = DIR_S;
      DIR_S:   r = DIR_L;
      default: r = DIR_N;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/robo_pose_tracker.sv
// Row/column/orientation registers, next-pose update and map-boundary checks.
module robo_pose_tracker #(
  parameter int ROWS = 10,
  parameter int COLS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] init_row,
  input  logic [4:0] init_col,
  input  logic [1:0] init_dir,
  input  logic       step_fwd,
  input  logic       step_turn,
  output logic [3:0] row,
  output logic [4:0] col,
  output logic [1:0] dir,
  output logic       init_legal,
  output logic       fwd_off_map
);
  import robo_pkg::*;

  localparam logic [3:0] ROW_MAX = 4'(ROWS);
  localparam logic [4:0] COL_MAX = 5'(COLS);

  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [1:0] dir_q, dir_d;

  always_comb begin
    init_legal = (init_row != 4'd0) && (init_row <= ROW_MAX) &&
                 (init_col != 5'd0) && (init_col <= COL_MAX);
    case (dir_q)
      DIR_N:   fwd_off_map = (row_q == 4'd1);
      DIR_S:   fwd_off_map = (row_q == ROW_MAX);
      DIR_L:   fwd_off_map = (col_q == COL_MAX);
      default: fwd_off_map = (col_q == 5'd1);
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    dir_d = dir_q;
    if (load) begin
      row_d = init_row;
      col_d = init_col;
      dir_d = init_dir;
    end else if (step_fwd) begin
      case (dir_q)
        DIR_N:   row_d = row_q - 4'd1;
        DIR_S:   row_d = row_q + 4'd1;
        DIR_L:   col_d = col_q + 5'd1;
        default: col_d = col_q - 5'd1;
      endcase
    end else if (step_turn) begin
      dir_d = turn_left(dir_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      dir_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      dir_q <= dir_d;
    end
  end

  assign row = row_q;
  assign col = col_q;
  assign dir = dir_q;

endmodule

// File: rtl/robo_mission_ctrl.sv
// Mission sequencer: one command at a time from the decision core, handshaked
// actuator requests, move budget and debris-removal bookkeeping.
//
// state      | meaning
// IDLE       | after reset, waiting for start
// RUN        | cmd_ready high, waiting for a command
// ISSUE_FWD  | forward request held until act_ready
// ISSUE_TURN | turn request held until act_ready
// ISSUE_REM  | remove request per debris unit, one low cycle between units
// STANDBY    | budget exhausted, waiting for start
// FAULT      | illegal command or start, waiting for start
module robo_mission_ctrl #(
  parameter int ROWS           = 10,
  parameter int COLS           = 20,
  parameter int BUDGET_W       = 8,
  parameter int DEFAULT_BUDGET = robo_pkg::DEFAULT_BUDGET
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          init_row,
  input  logic [4:0]          init_col,
  input  logic [1:0]          init_dir,
  input  logic [BUDGET_W-1:0] start_budget,
  input  logic                cmd_valid,
  input  logic                cmd_forward,
  input  logic                cmd_turn,
  input  logic                cmd_remove,
  output logic                cmd_ready,
  input  logic                barrier,
  input  logic [1:0]          debris_size,
  input  logic                act_ready,
  output logic                forward,
  output logic                turn,
  output logic                remove,
  output logic [3:0]          row,
  output logic [4:0]          col,
  output logic [1:0]          dir,
  output logic [BUDGET_W-1:0] moves_left,
  output logic [7:0]          removed_count,
  output logic                standby,
  output logic                fault
);
  import robo_pkg::*;

  robo_state_e         state_q, state_d;
  logic [BUDGET_W-1:0] moves_q, moves_d;
  logic [7:0]          removed_q, removed_d;
  logic [1:0]          units_q, units_d;
  logic                gap_q, gap_d;

  logic                pose_load, step_fwd, step_turn;
  logic                init_legal, fwd_off_map;
  logic                cmd_onehot;
  logic [BUDGET_W-1:0] moves_dec;
  logic [7:0]          removed_inc;

  robo_pose_tracker #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pose (
    .clock       (clock),
    .reset       (reset),
    .load        (pose_load),
    .init_row    (init_row),
    .init_col    (init_col),
    .init_dir    (init_dir),
    .step_fwd    (step_fwd),
    .step_turn   (step_turn),
    .row         (row),
    .col         (col),
    .dir         (dir),
    .init_legal  (init_legal),
    .fwd_off_map (fwd_off_map)
  );

  always_comb begin
    cmd_onehot  = ({cmd_forward, cmd_turn, cmd_remove} == 3'b100) ||
                  ({cmd_forward, cmd_turn, cmd_remove} == 3'b010) ||
                  ({cmd_forward, cmd_turn, cmd_remove} == 3'b001);
    moves_dec   = (moves_q == '0) ? moves_q : moves_q - BUDGET_W'(1);
    removed_inc = (removed_q == 8'hFF) ? removed_q : removed_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    moves_d   = moves_q;
    removed_d = removed_q;
    units_d   = units_q;
    gap_d     = gap_q;
    pose_load = 1'b0;
    step_fwd  = 1'b0;
    step_turn = 1'b0;
    cmd_ready = 1'b0;
    forward   = 1'b0;
    turn      = 1'b0;
    remove    = 1'b0;
    standby   = 1'b0;
    fault     = 1'b0;

    case (state_q)
      ST_IDLE, ST_STANDBY, ST_FAULT: begin
        standby = 1'b1;
        fault   = (state_q == ST_FAULT);
        if (start) begin
          if (init_legal) begin
            pose_load = 1'b1;
            moves_d   = (start_budget == '0) ? BUDGET_W'(DEFAULT_BUDGET) : start_budget;
            removed_d = '0;
            units_d   = '0;
            gap_d     = 1'b0;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_FAULT;
          end
        end
      end

      ST_RUN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_onehot) begin
            state_d = ST_FAULT;
          end else if (cmd_forward) begin
            state_d = (barrier || fwd_off_map) ? ST_FAULT : ST_ISSUE_FWD;
          end else if (cmd_turn) begin
            state_d = ST_ISSUE_TURN;
          end else if (!barrier || (debris_size == 2'd0)) begin
            state_d = ST_FAULT;
          end else begin
            units_d = debris_size;
            gap_d   = 1'b0;
            state_d = ST_ISSUE_REM;
          end
        end
      end

      ST_ISSUE_FWD: begin
        forward = 1'b1;
        if (act_ready) begin
          step_fwd = 1'b1;
          moves_d  = moves_dec;
          state_d  = (moves_dec == '0) ? ST_STANDBY : ST_RUN;
        end
      end

      ST_ISSUE_TURN: begin
        turn = 1'b1;
        if (act_ready) begin
          step_turn = 1'b1;
          moves_d   = moves_dec;
          state_d   = (moves_dec == '0) ? ST_STANDBY : ST_RUN;
        end
      end

      ST_ISSUE_REM: begin
        // gap_q is the mandatory low cycle between consecutive debris units
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          remove = 1'b1;
          if (act_ready) begin
            moves_d   = moves_dec;
            units_d   = units_q - 2'd1;
            removed_d = removed_inc;
            if (moves_dec == '0) begin
              units_d = '0;
              state_d = ST_STANDBY;
            end else if (units_q != 2'd1) begin
              gap_d   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      moves_q   <= '0;
      removed_q <= '0;
      units_q   <= '0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      moves_q   <= moves_d;
      removed_q <= removed_d;
      units_q   <= units_d;
      gap_q     <= gap_d;
    end
  end

  assign moves_left    = moves_q;
  assign removed_count = removed_q;

endmodule

// File: tb/tb_robo_mission_ctrl.sv
// Self-checking bench for robo_mission_ctrl: directed scenarios plus random
// traffic, every cycle compared against a mission-level reference model.
module tb_robo_mission_ctrl;

  localparam int ROWS = 10;
  localparam int COLS = 20;
  localparam int BW   = 8;

  localparam int MD_IDLE = 0, MD_RUN = 1, MD_BUSY = 2, MD_STBY = 3, MD_FAULT = 4;
  localparam int ACT_F = 0, ACT_T = 1, ACT_R = 2;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [3:0]    init_row;
  logic [4:0]    init_col;
  logic [1:0]    init_dir;
  logic [BW-1:0] start_budget;
  logic          cmd_valid, cmd_forward, cmd_turn, cmd_remove, cmd_ready;
  logic          barrier, act_ready;
  logic [1:0]    debris_size;
  logic          forward, turn, remove, standby, fault;
  logic [3:0]    row;
  logic [4:0]    col;
  logic [1:0]    dir;
  logic [BW-1:0] moves_left;
  logic [7:0]    removed_count;

  robo_mission_ctrl #(.ROWS(ROWS), .COLS(COLS), .BUDGET_W(BW), .DEFAULT_BUDGET(200)) dut (
    .clock(clock), .reset(reset), .start(start),
    .init_row(init_row), .init_col(init_col), .init_dir(init_dir),
    .start_budget(start_budget), .cmd_valid(cmd_valid),
    .cmd_forward(cmd_forward), .cmd_turn(cmd_turn), .cmd_remove(cmd_remove),
    .cmd_ready(cmd_ready), .barrier(barrier), .debris_size(debris_size),
    .act_ready(act_ready), .forward(forward), .turn(turn), .remove(remove),
    .row(row), .col(col), .dir(dir), .moves_left(moves_left),
    .removed_count(removed_count), .standby(standby), .fault(fault)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model: mission mode, pending action and bookkeeping as plain ints
  int m_mode = MD_IDLE, m_act = 0, m_units = 0, m_gap = 0;
  int m_row = 0, m_col = 0, m_dir = 0, m_moves = 0, m_removed = 0;

  // observation counters taken from the DUT
  int fwd_hi = 0, turn_hi = 0, rem_pulses = 0;
  logic prev_rem = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int left_of(input int d);
    // N=0 S=1 L=2 O=3; left turn N->O->S->L->N
    case (d)
      0: return 3;
      3: return 1;
      1: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int ir, ic, nr, nc, hot;
    ir = int'(init_row);
    ic = int'(init_col);
    if (reset) begin
      m_mode = MD_IDLE; m_act = 0; m_units = 0; m_gap = 0;
      m_row = 0; m_col = 0; m_dir = 0; m_moves = 0; m_removed = 0;
    end else begin
      case (m_mode)
        MD_IDLE, MD_STBY, MD_FAULT: if (start) begin
          if (ir >= 1 && ir <= ROWS && ic >= 1 && ic <= COLS) begin
            m_row = ir; m_col = ic; m_dir = int'(init_dir);
            m_moves = (start_budget == 0) ? 200 : int'(start_budget);
            m_removed = 0; m_mode = MD_RUN;
          end else m_mode = MD_FAULT;
        end
        MD_RUN: if (cmd_valid) begin
          hot = int'(cmd_forward) + int'(cmd_turn) + int'(cmd_remove);
          if (hot != 1) m_mode = MD_FAULT;
          else if (cmd_forward) begin
            nr = m_row + ((m_dir == 0) ? -1 : (m_dir == 1) ? 1 : 0);
            nc = m_col + ((m_dir == 2) ? 1 : (m_dir == 3) ? -1 : 0);
            if (barrier || nr < 1 || nr > ROWS || nc < 1 || nc > COLS) m_mode = MD_FAULT;
            else begin m_mode = MD_BUSY; m_act = ACT_F; end
          end else if (cmd_turn) begin
            m_mode = MD_BUSY; m_act = ACT_T;
          end else if (!barrier || debris_size == 0) m_mode = MD_FAULT;
          else begin m_mode = MD_BUSY; m_act = ACT_R; m_units = int'(debris_size); m_gap = 0; end
        end
        MD_BUSY: if (m_gap != 0) m_gap = 0;
        else if (act_ready) begin
          if (m_moves > 0) m_moves--;
          if (m_act == ACT_F) begin
            m_row += (m_dir == 0) ? -1 : (m_dir == 1) ? 1 : 0;
            m_col += (m_dir == 2) ? 1 : (m_dir == 3) ? -1 : 0;
          end else if (m_act == ACT_T) m_dir = left_of(m_dir);
          else begin
            m_units--;
            if (m_removed < 255) m_removed++;
          end
          if (m_moves == 0) m_mode = MD_STBY;
          else if (m_act == ACT_R && m_units > 0) m_gap = 1;
          else m_mode = MD_RUN;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    bit busy;
    busy = (m_mode == MD_BUSY) && (m_gap == 0);
    chk("cmd_ready", int'(cmd_ready), int'(m_mode == MD_RUN));
    chk("forward", int'(forward), int'(busy && m_act == ACT_F));
    chk("turn", int'(turn), int'(busy && m_act == ACT_T));
    chk("remove", int'(remove), int'(busy && m_act == ACT_R));
    chk("standby", int'(standby), int'(m_mode == MD_IDLE || m_mode == MD_STBY || m_mode == MD_FAULT));
    chk("fault", int'(fault), int'(m_mode == MD_FAULT));
    chk("row", int'(row), m_row);
    chk("col", int'(col), m_col);
    chk("dir", int'(dir), m_dir);
    chk("moves_left", int'(moves_left), m_moves);
    chk("removed_count", int'(removed_count), m_removed);
    if (forward) fwd_hi++;
    if (turn) turn_hi++;
    if (remove && !prev_rem) rem_pulses++;
    prev_rem = remove;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_start(input int r, input int c, input int d, input int b);
    start = 1'b1; init_row = 4'(r); init_col = 5'(c); init_dir = 2'(d);
    start_budget = BW'(b);
    step();
    start = 1'b0;
  endtask

  task automatic do_cmd(input bit f, input bit t, input bit r);
    cmd_valid = 1'b1; cmd_forward = f; cmd_turn = t; cmd_remove = r;
    step();
    cmd_valid = 1'b0; cmd_forward = 1'b0; cmd_turn = 1'b0; cmd_remove = 1'b0;
  endtask

  // acknowledge each actuator request after 'delay' extra high cycles
  task automatic serve(input int delay);
    int k = 0;
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready || standby) done = 1;
      else begin
        if (forward || turn || remove) begin
          act_ready = (k >= delay);
          k = act_ready ? 0 : k + 1;
        end else begin
          act_ready = 1'b0;
          k = 0;
        end
        step();
      end
    end
    act_ready = 1'b0;
    chk("serve_done", int'(done), 1);
  endtask

  initial begin
    int exp_dir[4];
    exp_dir = '{3, 1, 2, 0};
    reset = 1'b1; start = 1'b0; init_row = '0; init_col = '0; init_dir = '0;
    start_budget = '0; cmd_valid = 1'b0; cmd_forward = 1'b0; cmd_turn = 1'b0;
    cmd_remove = 1'b0; barrier = 1'b0; debris_size = '0; act_ready = 1'b0;
    repeat (3) step();
    chk("rst_standby", int'(standby), 1);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_moves", int'(moves_left), 0);
    reset = 1'b0;
    step();

    // forward with a two-cycle actuator delay
    do_start(5, 3, 0, 10);
    fwd_hi = 0;
    do_cmd(1, 0, 0);
    serve(2);
    chk("fwd_high_cycles", fwd_hi, 3);
    chk("fwd_row", int'(row), 4);
    chk("fwd_moves", int'(moves_left), 9);
    chk("fwd_cmd_ready", int'(cmd_ready), 1);
    chk("model_fwd_row", m_row, 4);

    // four left turns from N
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 1, 0);
      serve(0);
      chk("turn_dir", int'(dir), exp_dir[i]);
    end
    chk("turn_moves", int'(moves_left), 5);
    chk("model_turn_moves", m_moves, 5);

    // remove three units of debris
    barrier = 1'b1; debris_size = 2'd3; rem_pulses = 0;
    do_cmd(0, 0, 1);
    serve(0);
    chk("rem_pulses", rem_pulses, 3);
    chk("rem_count", int'(removed_count), 3);
    chk("rem_moves", int'(moves_left), 2);

    // budget runs out mid-removal
    reset = 1'b1; step(); reset = 1'b0;
    do_start(5, 3, 0, 2);
    rem_pulses = 0;
    do_cmd(0, 0, 1);
    serve(0);
    chk("bud_pulses", rem_pulses, 2);
    chk("bud_standby", int'(standby), 1);
    chk("bud_count", int'(removed_count), 2);
    chk("model_bud_count", m_removed, 2);
    barrier = 1'b0;
    cmd_valid = 1'b1; cmd_forward = 1'b1;
    repeat (3) step();
    cmd_valid = 1'b0; cmd_forward = 1'b0;
    chk("bud_ignored_row", int'(row), 5);
    chk("bud_ignored_ready", int'(cmd_ready), 0);

    // forward off the map, then forward into a barrier
    do_start(1, 3, 0, 10);
    fwd_hi = 0;
    do_cmd(1, 0, 0);
    chk("edge_fault", int'(fault), 1);
    chk("edge_row", int'(row), 1);
    step();
    chk("edge_no_pulse", fwd_hi, 0);
    do_start(5, 3, 0, 10);
    chk("restart_fault", int'(fault), 0);
    barrier = 1'b1;
    do_cmd(1, 0, 0);
    chk("barrier_fault", int'(fault), 1);
    chk("barrier_row", int'(row), 5);
    do_start(5, 3, 0, 10);
    chk("restart2_fault", int'(fault), 0);
    chk("restart2_standby", int'(standby), 0);

    // reset while a removal is waiting for act_ready
    debris_size = 2'd2;
    do_cmd(0, 0, 1);
    step();
    chk("midrst_rem_before", int'(remove), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_remove", int'(remove), 0);
    chk("midrst_standby", int'(standby), 1);
    chk("midrst_moves", int'(moves_left), 0);

    // zero budget selects the default; start is ignored while running; bad start pose
    do_start(5, 3, 2, 0);
    chk("default_budget", int'(moves_left), 200);
    do_start(0, 3, 0, 4);
    chk("run_start_ignored", int'(fault), 0);
    reset = 1'b1; step(); reset = 1'b0;
    do_start(11, 3, 0, 5);
    chk("bad_row_fault", int'(fault), 1);
    do_start(5, 21, 0, 5);
    chk("bad_col_fault", int'(fault), 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 24) == 0);
      init_row = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, ROWS));
      init_col = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, COLS));
      init_dir = 2'($urandom_range(0, 3));
      start_budget = ($urandom_range(0, 5) == 0) ? '0 : BW'($urandom_range(1, 30));
      cmd_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) begin
        int sel;
        sel = $urandom_range(0, 2);
        cmd_forward = (sel == 0); cmd_turn = (sel == 1); cmd_remove = (sel == 2);
      end else begin
        cmd_forward = $urandom_range(0, 1) == 1;
        cmd_turn = $urandom_range(0, 1) == 1;
        cmd_remove = $urandom_range(0, 1) == 1;
      end
      barrier = ($urandom_range(0, 2) == 0);
      debris_size = 2'($urandom_range(0, 3));
      act_ready = ($urandom_range(0, 4) < 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
